// File: rtl/board_input_ctrl.sv
// Board input path: synchronises and debounces switches/buttons, latches button
// presses in sticky flags and exposes them on a word-addressed CPU read port.
module board_input_ctrl #(
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned BTN_WIDTH       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR       = 32'h00000080
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [BTN_WIDTH-1:0] btn,
    input  logic [31:0]          readadr,
    input  logic                 readen,
    output logic [31:0]          readdata,
    output logic                 pressflag
);

    localparam int unsigned IN_W  = SW_WIDTH + BTN_WIDTH;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_W-1:0]      r_s1;
    logic [IN_W-1:0]      r_s2;
    logic [IN_W-1:0]      r_stable;
    logic [CNT_W-1:0]     r_cnt [IN_W];
    logic [BTN_WIDTH-1:0] r_flag;
    logic [15:0]          r_press_cnt;
    logic [31:0]          r_readdata;

    logic [IN_W-1:0]      w_done;
    logic [BTN_WIDTH-1:0] w_btn_rise;
    logic [15:0]          w_rise_cnt;
    logic [31:0]          w_offset;
    logic                 w_in_range;
    logic                 w_clear;
    logic [31:0]          w_rdata;

    // Two-flop synchroniser on the concatenated {btn, sw} pin vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {btn, sw};
            r_s2 <= r_s1;
        end
    end

    // A bit commits when it has disagreed with its stable level for the full window
    always_comb begin
        for (int i = 0; i < int'(IN_W); i++) begin
            w_done[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable <= '0;
            for (int i = 0; i < int'(IN_W); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(IN_W); i++) begin
                if (r_s2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_done[i]) begin
                    r_stable[i] <= r_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of a stable button is known in the cycle it commits
    assign w_btn_rise = w_done[IN_W-1:SW_WIDTH] & r_s2[IN_W-1:SW_WIDTH];

    always_comb begin
        w_rise_cnt = '0;
        for (int i = 0; i < int'(BTN_WIDTH); i++) begin
            w_rise_cnt = w_rise_cnt + 16'(w_btn_rise[i]);
        end
    end

    assign w_offset   = readadr - BASE_ADDR;
    assign w_in_range = (w_offset[31:4] == 28'd0) && (w_offset[1:0] == 2'b00)
                        && (readadr[1:0] == 2'b00);
    assign w_clear    = readen && w_in_range && (w_offset[3:2] == 2'd1);
    assign pressflag  = |r_flag;

    // Clear and set on the same edge: a new press wins over the read-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag      <= '0;
            r_press_cnt <= '0;
        end else begin
            r_flag      <= (w_clear ? '0 : r_flag) | w_btn_rise;
            r_press_cnt <= r_press_cnt + w_rise_cnt;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_in_range) begin
            case (w_offset[3:2])
                2'd0: w_rdata = 32'(r_stable[SW_WIDTH-1:0]);
                2'd1: begin
                    w_rdata[BTN_WIDTH-1:0] = r_flag;
                    w_rdata[31]            = pressflag;
                end
                2'd2:    w_rdata = 32'(r_stable[IN_W-1:SW_WIDTH]);
                default: w_rdata = 32'(r_press_cnt);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_readdata <= '0;
        end else if (readen) begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_board_input_ctrl.sv
// Scenario bench for board_input_ctrl with a 4-cycle debounce window at base 0x80.
module tb_board_input_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [3:0]  btn;
    logic [31:0] readadr;
    logic        readen;
    logic [31:0] readdata;
    logic        pressflag;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb [$];
    logic [31:0] e;

    board_input_ctrl #(
        .SW_WIDTH        (16),
        .BTN_WIDTH       (4),
        .DEBOUNCE_CYCLES (4),
        .BASE_ADDR       (32'h00000080)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .btn       (btn),
        .readadr   (readadr),
        .readen    (readen),
        .readdata  (readdata),
        .pressflag (pressflag)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one read strobe for the next edge, logging the value it must return
    task automatic issue_read(input logic [31:0] a, input logic [31:0] exp);
        readadr = a;
        readen  = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        readen  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sw = 16'hA5C3; btn = '0; readadr = '0; readen = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (readdata !== 32'h0) $display("FAIL reset_readdata got=%h exp=0", readdata); else n_pass++;
        n_checks++; if (pressflag !== 1'b0) $display("FAIL reset_pressflag got=%b exp=0", pressflag); else n_pass++;
        idle(2);
        reset = 1'b1;
    endtask

    task automatic test_sw();
        idle(4);
        issue_read(32'h80, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL sw_early5 got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h80, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL sw_early6 got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h80, 32'h0000A5C3);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL sw_data got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h88, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL sw_btnlevel got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    task automatic test_glitch();
        btn[2] = 1'b1;
        idle(3);
        btn[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (pressflag !== 1'b0) $display("FAIL glitch_pressflag cyc=%0d got=%b exp=0", i, pressflag); else n_pass++;
        end
        issue_read(32'h84, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL glitch_status got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h8C, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL glitch_count got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    task automatic test_press();
        btn[1] = 1'b1;
        idle(5);
        n_checks++; if (pressflag !== 1'b0) $display("FAIL press_flag_edge5 got=%b exp=0", pressflag); else n_pass++;
        idle(1);
        n_checks++; if (pressflag !== 1'b1) $display("FAIL press_flag_edge6 got=%b exp=1", pressflag); else n_pass++;
        idle(4);
        btn[1] = 1'b0;
        idle(8);
        issue_read(32'h84, 32'h80000002);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL press_status got=%h exp=%h", readdata, e); else n_pass++;
        n_checks++; if (pressflag !== 1'b0) $display("FAIL press_cleared got=%b exp=0", pressflag); else n_pass++;
        issue_read(32'h84, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL press_status2 got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h8C, 32'h1);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL press_count got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h88, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL press_level got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    task automatic test_clear_race();
        btn[0] = 1'b1;
        idle(5);
        issue_read(32'h84, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL race_status got=%h exp=%h", readdata, e); else n_pass++;
        n_checks++; if (pressflag !== 1'b1) $display("FAIL race_pressflag got=%b exp=1", pressflag); else n_pass++;
        issue_read(32'h84, 32'h80000001);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL race_status2 got=%h exp=%h", readdata, e); else n_pass++;
        btn[0] = 1'b0;
        idle(8);
        issue_read(32'h8C, 32'h2);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL race_count got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    task automatic test_count_wrap();
        force dut.r_press_cnt = 16'hFFFF;
        #1 release dut.r_press_cnt;
        issue_read(32'h8C, 32'h0000FFFF);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL wrap_preload got=%h exp=%h", readdata, e); else n_pass++;
        btn[2] = 1'b1;
        idle(8);
        btn[2] = 1'b0;
        idle(8);
        issue_read(32'h8C, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL wrap_count got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h84, 32'h80000004);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL wrap_status got=%h exp=%h", readdata, e); else n_pass++;
        btn = 4'b0011;
        idle(8);
        btn = 4'b0000;
        idle(8);
        issue_read(32'h8C, 32'h2);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL multi_count got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h84, 32'h80000003);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL multi_status got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    task automatic test_reset_midread();
        btn[3] = 1'b1;
        idle(8);
        n_checks++; if (pressflag !== 1'b1) $display("FAIL rst_pre_flag got=%b exp=1", pressflag); else n_pass++;
        issue_read(32'h88, 32'h8);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL rst_pre_level got=%h exp=%h", readdata, e); else n_pass++;
        readadr = 32'h8C;
        readen  = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_checks++; if (readdata !== 32'h0) $display("FAIL rst_async_data got=%h exp=0", readdata); else n_pass++;
        n_checks++; if (pressflag !== 1'b0) $display("FAIL rst_async_flag got=%b exp=0", pressflag); else n_pass++;
        @(negedge clk);
        readen = 1'b0;
        idle(1);
        reset = 1'b1;
        issue_read(32'h84, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL rst_status got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h8C, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL rst_count got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h90, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL rst_unmapped got=%h exp=%h", readdata, e); else n_pass++;
        issue_read(32'h81, 32'h0);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL rst_misaligned got=%h exp=%h", readdata, e); else n_pass++;
        idle(1);
        n_checks++; if (pressflag !== 1'b0) $display("FAIL held_flag_edge5 got=%b exp=0", pressflag); else n_pass++;
        idle(1);
        n_checks++; if (pressflag !== 1'b1) $display("FAIL held_flag_edge6 got=%b exp=1", pressflag); else n_pass++;
        btn[3] = 1'b0;
        issue_read(32'h8C, 32'h1);
        e = sb.pop_front(); n_checks++; if (readdata !== e) $display("FAIL held_count got=%h exp=%h", readdata, e); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_glitch();
        test_press();
        test_clear_race();
        test_count_wrap();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/board_input_ctrl.md
Name: board_input_ctrl

Overview:
- Board-side input path, the inbound counterpart to the seven-segment display path: the CPU writes results out to the display, and this block brings user input back to the CPU.
- Takes raw slide switches and push buttons, synchronises and debounces them, and records button presses in sticky flags.
- Exposes four word registers on a memory-mapped read port that the MIPS core reads with lw.
- Sits between the board pins and the top-level data-memory read mux.

Parameters:
- SW_WIDTH, 16, number of slide switches.
- BTN_WIDTH, 4, number of push buttons (max 8).
- DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new level before it is accepted (bench uses 4; minimum 2).
- BASE_ADDR, 32'h00000080, byte address of register 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- sw  in  SW_WIDTH  raw switch pins, asynchronous to clk.
- btn  in  BTN_WIDTH  raw button pins, asynchronous to clk, 1 = pressed.
- readadr  in  32  CPU byte read address.
- readen  in  1  CPU read strobe, one cycle per access.
- readdata  out  32  registered read data.
- pressflag  out  1  OR of all sticky press flags (level, CPU poll/LED).

Behaviour:
- Reset (reset=0, async): sync flops, stable levels, debounce counters, press flags, press count and readdata all go to 0; pressflag=0. Release is taken on a clk edge.
- Synchroniser: each sw/btn bit passes through 2 flops (s1→s2) before any other use.
- Debounce, independent per bit:
  - s2==stable: counter←0.
  - s2!=stable and counter<DEBOUNCE_CYCLES-1: counter++.
  - s2!=stable and counter==DEBOUNCE_CYCLES-1: stable←s2, counter←0.
  - Raw→stable latency is exactly DEBOUNCE_CYCLES+2 edges.
  - A pulse shorter than DEBOUNCE_CYCLES cycles after sync never changes stable.
- Press detection: a 0→1 transition of stable btn[i] sets flag[i] and increments press_count (16 bit, wraps FFFF→0000). Several buttons in one cycle add one count per button.
- Register map (offset from BASE_ADDR, word aligned):
  - 0x0 SW_DATA: {zeros, stable sw}.
  - 0x4 BTN_STATUS: bit31=pressflag, bits[BTN_WIDTH-1:0]=flags, others 0. Read-to-clear.
  - 0x8 BTN_LEVEL: {zeros, stable btn}.
  - 0xC PRESS_COUNT: {16'b0, press_count}.
  - Any other address, or readadr[1:0]!=0: readdata←0, no side effects.
- Read timing: readen=1 at edge N loads readdata at edge N; the value is valid from N until the next readen. With readen=0, readdata holds.
- Read-to-clear rule: on a BTN_STATUS read, readdata captures the pre-clear flags and all flags clear at the same edge.
  - If a new press of button i lands on the clearing edge, flag[i] ends at 1 (set wins), and the returned value shows the pre-set state.
  - The count is never cleared by reads.
- pressflag is combinational OR of the flags, so it follows them with no extra latency.
- Reset mid-debounce discards partial counts. Stable is 0 after reset, so a button held through reset produces one press event DEBOUNCE_CYCLES+2 edges after release.

Test Plan (DEBOUNCE_CYCLES=4, BASE_ADDR=0x80):
- Reset, sw=16'hA5C3 held, wait 6 cycles, read 0x80 → readdata=32'h0000A5C3. Reading before 6 cycles returns 0.
- btn[2] high for 3 cycles then low → stable never changes, read 0x84=0, read 0x8C=0, pressflag=0 throughout.
- btn[1] held 10 cycles → pressflag rises 6 edges after btn rises. Read 0x84 → 32'h80000002, then a second read 0x84 → 0. Read 0x8C → 1.
- Align a BTN_STATUS read with the edge where btn[0] becomes stable → that read returns 0; pressflag stays 1; next read returns 32'h80000001.
- Preload press_count to FFFF via 65535 presses (or a forced-value bench) and add one press → read 0x8C = 0.
- Press btn[3], then drive reset=0 mid-read between clk edges → readdata and pressflag go to 0 immediately. Reads of 0x84 and 0x8C after release return 0. Read 0x90 returns 0.
